display_scanner: RTL and testbench

DISPLAY_SCANNER -- requirements
Module: display_scanner

---
 rtl/display_scanner.sv | 85 ++++++++
 tb/tb_display_scanner.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_scanner.sv
// Four-digit multiplexed seven-segment scanner with per-slot anti-ghosting gap,
// frame-synchronous value update and a registered frame_done pulse.
module display_scanner #(
  parameter int DIV = 50000,
  parameter int GAP = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic [3:0]  blank,
  output logic [3:0]  num,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_C = CW'(GAP);

  typedef enum logic {S_GAP, S_SHOW} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    digit, digit_n;
  logic          wrap, boundary;
  logic [15:0]   active, active_n, pending;
  logic          pending_valid;
  logic [3:0]    an_n;

  // Outputs are registered from next-cycle values so they line up with the
  // cnt/digit/state registers that update on the same edge.
  always_comb begin
    wrap     = (cnt == LAST);
    boundary = wrap && (digit == 2'd3);
    cnt_n    = wrap ? '0 : cnt + CW'(1);
    digit_n  = wrap ? digit + 2'd1 : digit;

    state_n = state;
    case (state)
      S_GAP:   if (cnt_n == GAP_C) state_n = S_SHOW;
      S_SHOW:  if (wrap) state_n = S_GAP;
      default: state_n = S_GAP;
    endcase

    active_n = active;
    if (boundary) begin
      if (load)               active_n = value_in;
      else if (pending_valid) active_n = pending;
    end

    an_n = '1;
    if (state_n == S_SHOW && !blank[digit_n]) an_n[digit_n] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      digit         <= '0;
      state         <= S_GAP;
      active        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      num           <= '0;
      an            <= '1;
      frame_done    <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      digit  <= digit_n;
      state  <= state_n;
      active <= active_n;
      // A load on the boundary goes straight to active, so pending is dropped.
      if (boundary) begin
        pending_valid <= 1'b0;
      end else if (load) begin
        pending       <= value_in;
        pending_valid <= 1'b1;
      end
      num        <= active_n[{digit_n, 2'b00} +: 4];
      an         <= an_n;
      frame_done <= (digit_n == 2'd3) && (cnt_n == LAST);
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Randomised self-checking bench for display_scanner (DIV=8, GAP=2) against a
// time-indexed reference model of slots, frames and value hand-over.
module tb_display_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value_in = '0;
  logic        load = 1'b0;
  logic [3:0]  blank = '0;
  logic [3:0]  num, an;
  logic        frame_done;

  display_scanner #(.DIV(8), .GAP(2)) dut (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .load(load),
    .blank(blank), .num(num), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_err = 0;
  int          t;
  logic [15:0] m_act, m_pend;
  bit          m_pv;
  logic [3:0]  exp_an, exp_num;
  logic        exp_fd;

  // Model: t counts edges since reset release; frame of 32 cycles, slot of 8.
  task automatic model_reset();
    t = 0; m_act = '0; m_pend = '0; m_pv = 0;
    exp_an = 4'hF; exp_num = '0; exp_fd = 1'b0;
  endtask

  task automatic tick();
    logic [3:0] b;
    int pos, dig;
    b = blank;
    if (t % 32 == 31) begin
      if (load) begin m_act = value_in; m_pv = 0; end
      else if (m_pv) begin m_act = m_pend; m_pv = 0; end
    end else if (load) begin
      m_pend = value_in; m_pv = 1;
    end
    @(posedge clk); #1;
    t++;
    pos = t % 8;
    dig = (t / 8) % 4;
    exp_fd  = (t % 32 == 31);
    exp_num = 4'(m_act >> (4 * dig));
    exp_an  = (pos >= 2 && !b[dig]) ? 4'(~(4'b0001 << dig)) : 4'hF;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({an, num, frame_done} !== {4'hF, 4'h0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_held an=%b num=%h fd=%b expected 1111/0/0", an, num, frame_done);
    end
    rst_n = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if ({an, num, frame_done} !== {exp_an, exp_num, exp_fd}) begin
      n_err++;
      $display("FAIL reset_release an=%b num=%h fd=%b expected an=%b num=%h fd=%b",
               an, num, frame_done, exp_an, exp_num, exp_fd);
    end
  endtask

  task automatic test_idle_frames();
    repeat (64) begin
      tick();
      n_cmp++;
      if ({an, num, frame_done} !== {exp_an, exp_num, exp_fd}) begin
        n_err++;
        $display("FAIL idle t=%0d an=%b num=%h fd=%b expected an=%b num=%h fd=%b",
                 t, an, num, frame_done, exp_an, exp_num, exp_fd);
      end
    end
  endtask

  task automatic test_load_deferred();
    logic [3:0] want [4] = '{4'h3, 4'hC, 4'h5, 4'hA};
    apply_reset();
    while (t < 64) begin
      load = (t == 4);
      value_in = 16'hA5C3;
      tick();
      load = 1'b0;
      n_cmp++;
      if ({an, num, frame_done} !== {exp_an, exp_num, exp_fd}) begin
        n_err++;
        $display("FAIL deferred t=%0d an=%b num=%h fd=%b expected an=%b num=%h fd=%b",
                 t, an, num, frame_done, exp_an, exp_num, exp_fd);
      end
      if (t >= 32 && t % 8 == 4) begin
        n_cmp++;
        if (num !== want[(t / 8) % 4]) begin
          n_err++;
          $display("FAIL deferred_digit t=%0d num=%h expected %h", t, num, want[(t / 8) % 4]);
        end
      end
    end
  endtask

  task automatic test_last_wins();
    apply_reset();
    while (t < 64) begin
      load = (t == 2) || (t == 19);
      value_in = (t == 2) ? 16'h1111 : 16'h2222;
      tick();
      load = 1'b0;
      n_cmp++;
      if ({an, num, frame_done} !== {exp_an, exp_num, exp_fd}) begin
        n_err++;
        $display("FAIL last_wins t=%0d an=%b num=%h fd=%b expected an=%b num=%h fd=%b",
                 t, an, num, frame_done, exp_an, exp_num, exp_fd);
      end
      if (t >= 32) begin
        n_cmp++;
        if (num !== 4'h2) begin
          n_err++;
          $display("FAIL last_wins_value t=%0d num=%h expected 2", t, num);
        end
      end
    end
  endtask

  task automatic test_boundary_load();
    int stop;
    stop = t + 32 - (t % 32) + 32;
    while (t < stop) begin
      load = (t % 32 == 25) || (t % 32 == 31);
      value_in = (t % 32 == 31) ? 16'hBEEF : 16'h7777;
      if (t >= stop - 32) load = 1'b0;
      tick();
      load = 1'b0;
      n_cmp++;
      if ({an, num, frame_done} !== {exp_an, exp_num, exp_fd}) begin
        n_err++;
        $display("FAIL boundary_load t=%0d an=%b num=%h fd=%b expected an=%b num=%h fd=%b",
                 t, an, num, frame_done, exp_an, exp_num, exp_fd);
      end
    end
  endtask

  task automatic test_blank();
    while (t % 32 != 31) tick();
    blank = 4'b0101;
    repeat (36) begin
      tick();
      n_cmp++;
      if ({an, num, frame_done} !== {exp_an, exp_num, exp_fd}) begin
        n_err++;
        $display("FAIL blank t=%0d an=%b num=%h fd=%b expected an=%b num=%h fd=%b",
                 t, an, num, frame_done, exp_an, exp_num, exp_fd);
      end
    end
    blank = '0;
  endtask

  task automatic test_random();
    repeat (320) begin
      load     = ($urandom_range(0, 7) == 0);
      value_in = 16'($urandom);
      if ($urandom_range(0, 15) == 0) blank = 4'($urandom);
      tick();
      load = 1'b0;
      n_cmp++;
      if ({an, num, frame_done} !== {exp_an, exp_num, exp_fd}) begin
        n_err++;
        $display("FAIL random t=%0d an=%b num=%h fd=%b expected an=%b num=%h fd=%b",
                 t, an, num, frame_done, exp_an, exp_num, exp_fd);
      end
    end
    blank = '0;
  endtask

  task automatic test_reset_midframe();
    while (t % 32 != 18) tick();
    load = 1'b1;
    value_in = 16'h9999;
    tick();
    load = 1'b0;
    rst_n = 1'b0;
    load = 1'b1;
    value_in = 16'hFFFF;
    #1;
    n_cmp++;
    if ({an, num, frame_done} !== {4'hF, 4'h0, 1'b0}) begin
      n_err++;
      $display("FAIL midreset_async an=%b num=%h fd=%b expected 1111/0/0", an, num, frame_done);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({an, num, frame_done} !== {4'hF, 4'h0, 1'b0}) begin
      n_err++;
      $display("FAIL midreset_held an=%b num=%h fd=%b expected 1111/0/0", an, num, frame_done);
    end
    load = 1'b0;
    rst_n = 1'b1;
    model_reset();
    repeat (48) begin
      tick();
      n_cmp++;
      if ({an, num, frame_done} !== {exp_an, exp_num, exp_fd}) begin
        n_err++;
        $display("FAIL midreset_after t=%0d an=%b num=%h fd=%b expected an=%b num=%h fd=%b",
                 t, an, num, frame_done, exp_an, exp_num, exp_fd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_frames();
    test_load_deferred();
    test_last_wins();
    test_boundary_load();
    test_blank();
    test_random();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
